dcc_rx: RTL and testbench
=========================

Name: dcc_rx

Overview:
- DCC track-signal receiver/decoder; the receive counterpart of the team's DCC packet transmitter and bit encoder.
- Samples the raw track polarity, measures half-bit widths, slices them into 1/0 bits, frames preamble, bytes, separators and end bit, and checks the XOR error byte.
- Presents each valid packet as one flat word plus a length, one cycle at a time.
- Sits behind the track-sense input; feeds the command loopback checker and the decoder-side logic.

Parameters:
- ONE_MIN, 52, minimum '1' half-bit width in clk cycles (defaults assume 1 MHz clk).
- ONE_MAX, 64, maximum '1' half-bit width.
- ZERO_MIN, 90, minimum '0' half-bit width.
- ZERO_MAX, 10000, maximum '0' half-bit width.
- CNT_W, 16, half-bit counter width; must hold ZERO_MAX+1.
- PREAMBLE_MIN, 10, consecutive '1' bits required before a start bit is accepted.
- MAX_BYTES, 6, maximum bytes per packet, error byte included.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- track_in, input, 1, asynchronous raw track polarity.
- pkt_valid, output, 1, one-cycle pulse: good packet available.
- pkt_data, output, 8*MAX_BYTES, packet bytes; byte0 in [7:0]; error byte excluded; unused bytes 0.
- pkt_len, output, 3, number of data bytes, error byte excluded.
- pkt_err, output, 1, one-cycle pulse: packet rejected.
- err_code, output, 2, 00 checksum, 01 timing, 10 overflow, 11 too short; valid with pkt_err.

Behaviour:
- Reset: all outputs 0. FSM in PREAMBLE with ones count 0. Slicer pending flag cleared. Synchronizer flops at 0.
- Reset asserted mid-packet discards any partial packet; no pulse is emitted.
- Slicer, input path: 2-flop synchronizer, then edge detect on either polarity.
- Slicer, counter: counts clk cycles since the last edge and saturates at ZERO_MAX+1.
- Slicer, classification on each edge:
  - ONE_MIN..ONE_MAX gives ONE.
  - ZERO_MIN..ZERO_MAX gives ZERO.
  - Anything else gives BAD.
  - Saturation without an edge gives BAD immediately, once.
- Slicer, pairing:
  - First classified half is held as pending.
  - If the second half has the same class, emit bit_valid with bit_val (1 for ONE, 0 for ZERO) and clear pending.
  - If the classes differ, emit no bit and keep the second half as the new pending (phase resync).
  - BAD emits bit_err and clears pending.
- FSM state PREAMBLE:
  - Bit 1: increment ones count, saturating at 31.
  - Bit 0 with ones count >= PREAMBLE_MIN: go to BYTE; clear byte index, XOR accumulator and buffer.
  - Bit 0 with fewer ones: clear ones count.
  - bit_err: clear ones count; no error pulse.
- FSM state BYTE:
  - Shift in 8 bits MSB first.
  - On the 8th bit: store the byte at the byte index, XOR it into the accumulator, increment the index, go to SEP.
- FSM state SEP:
  - Bit 0 with index < MAX_BYTES: go to BYTE.
  - Bit 0 with index == MAX_BYTES: pkt_err with code 10, go to PREAMBLE.
  - Bit 1 (end bit):
    - index < 3: code 11.
    - Otherwise, accumulator != 0: code 00.
    - Otherwise: pkt_valid.
    - In every case go to PREAMBLE with ones count = 1; the end bit counts as preamble.
- bit_err in BYTE or SEP: pkt_err with code 01, go to PREAMBLE with ones count 0.
- Latency: pkt_valid/pkt_err asserted the cycle after the slicer reports the end bit.
- pkt_data and pkt_len are registered at that same cycle and hold until the next pkt_valid.
- pkt_valid and pkt_err are never asserted together.
- Edge and saturation on the same cycle: the edge wins and the counter restarts at 1.

Optional Feature:
- Macro DCC_RX_STATS_EN.
- When defined, adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - They increment on pkt_valid and on pkt_err respectively.
  - Both wrap at 0xFFFF to 0 and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package dcc_pkg holds:
  - half-bit class encoding (ONE/ZERO/BAD);
  - err_code constants (ERR_CHECKSUM, ERR_TIMING, ERR_OVERFLOW, ERR_SHORT);
  - FSM state encoding (PREAMBLE, BYTE, SEP);
  - default timing constants.
- One sub-module, dcc_bit_slicer: synchronizer, edge detect, counter, classification and pairing; outputs bit_valid, bit_val, bit_err.
- dcc_rx instantiates it and holds the framing FSM and the packet buffer.

Test Plan:
- Idle packet: 14 ones, then bytes FF, 00, FF with correct separators and end bit -> pkt_valid once, pkt_len=2, pkt_data[15:0]=16'h00FF, pkt_err never set.
- Bad checksum: bytes 03, 3F, 3D (correct error byte is 3C) -> pkt_err, err_code=00, no pkt_valid.
- Short preamble: 9 ones, then a valid 03, 3F, 3C frame -> no pulse at all. Same frame after 10 ones -> pkt_valid, pkt_len=2, pkt_data[15:0]=16'h3F03.
- Timing error: one half-bit held 12000 cycles mid-byte -> pkt_err, err_code=01. A following valid packet is then accepted.
- Overflow: 7 bytes separated by 0 bits -> pkt_err, err_code=10 when the 7th byte would start; no pkt_valid.
- Reset, and back-to-back packets:
  - Reset asserted during byte 2 -> outputs 0, no pulse.
  - Two packets where the second has only 9 further ones after the first end bit -> both pkt_valid, since the end bit counts toward the preamble.

Source files
------------

// File: rtl/dcc_pkg.sv
// Shared types and defaults for the DCC receive path: half-bit classes,
// framing FSM states, rejection codes and timing defaults (1 MHz clock).
package dcc_pkg;

  localparam int DEF_ONE_MIN      = 52;
  localparam int DEF_ONE_MAX      = 64;
  localparam int DEF_ZERO_MIN     = 90;
  localparam int DEF_ZERO_MAX     = 10000;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_PREAMBLE_MIN = 10;
  localparam int DEF_MAX_BYTES    = 6;

  typedef enum logic [1:0] {
    HB_ONE  = 2'b00,
    HB_ZERO = 2'b01,
    HB_BAD  = 2'b10
  } hb_class_e;

  typedef enum logic [1:0] {
    PREAMBLE = 2'b00,
    BYTE     = 2'b01,
    SEP      = 2'b10
  } rx_state_e;

  localparam logic [1:0] ERR_CHECKSUM = 2'b00;
  localparam logic [1:0] ERR_TIMING   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_SHORT    = 2'b11;

endpackage

// File: rtl/dcc_bit_slicer.sv
// DCC half-bit slicer: synchronizes the track polarity, times each half-bit,
// classifies it and pairs matching halves into bits.
module dcc_bit_slicer
  import dcc_pkg::*;
#(
  parameter int ONE_MIN  = DEF_ONE_MIN,
  parameter int ONE_MAX  = DEF_ONE_MAX,
  parameter int ZERO_MIN = DEF_ZERO_MIN,
  parameter int ZERO_MAX = DEF_ZERO_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic track_in,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_err
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ZERO_MAX + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  hb_class_e        r_pend_cls;
  logic             r_bit_valid;
  logic             r_bit_val;
  logic             r_bit_err;

  logic             w_edge;
  logic             w_sat_hit;
  logic             w_cls_valid;
  hb_class_e        w_cls;

  assign w_edge    = r_sync2 ^ r_prev;
  // Fires only on the cycle the counter steps onto its saturation value.
  assign w_sat_hit = !w_edge && (r_cnt == CNT_SAT - CNT_W'(1));

  always_comb begin
    w_cls_valid = 1'b0;
    w_cls       = HB_BAD;
    if (w_edge) begin
      w_cls_valid = 1'b1;
      if ((r_cnt >= CNT_W'(ONE_MIN)) && (r_cnt <= CNT_W'(ONE_MAX))) begin
        w_cls = HB_ONE;
      end else if ((r_cnt >= CNT_W'(ZERO_MIN)) && (r_cnt <= CNT_W'(ZERO_MAX))) begin
        w_cls = HB_ZERO;
      end else begin
        w_cls = HB_BAD;
      end
    end else if (w_sat_hit) begin
      w_cls_valid = 1'b1;
      w_cls       = HB_BAD;
    end else begin
      w_cls_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_sync1 <= track_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A mismatched second half becomes the new pending half, realigning bit phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= 1'b0;
      r_pend_cls  <= HB_BAD;
      r_bit_valid <= 1'b0;
      r_bit_val   <= 1'b0;
      r_bit_err   <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      r_bit_err   <= 1'b0;
      if (w_cls_valid) begin
        if (w_cls == HB_BAD) begin
          r_bit_err <= 1'b1;
          r_pend    <= 1'b0;
        end else if (r_pend && (r_pend_cls == w_cls)) begin
          r_bit_valid <= 1'b1;
          r_bit_val   <= (w_cls == HB_ONE);
          r_pend      <= 1'b0;
        end else begin
          r_pend     <= 1'b1;
          r_pend_cls <= w_cls;
        end
      end
    end
  end

  assign bit_valid = r_bit_valid;
  assign bit_val   = r_bit_val;
  assign bit_err   = r_bit_err;

endmodule

// File: rtl/dcc_rx.sv
// DCC packet receiver: frames sliced bits into preamble/bytes/end bit and checks
// the XOR error byte. DCC_RX_STATS_EN adds good/bad packet counters.
module dcc_rx
  import dcc_pkg::*;
#(
  parameter int ONE_MIN      = DEF_ONE_MIN,
  parameter int ONE_MAX      = DEF_ONE_MAX,
  parameter int ZERO_MIN     = DEF_ZERO_MIN,
  parameter int ZERO_MAX     = DEF_ZERO_MAX,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PREAMBLE_MIN = DEF_PREAMBLE_MIN,
  parameter int MAX_BYTES    = DEF_MAX_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   track_in,
  output logic                   pkt_valid,
  output logic [8*MAX_BYTES-1:0] pkt_data,
  output logic [2:0]             pkt_len,
  output logic                   pkt_err,
  output logic [1:0]             err_code
`ifdef DCC_RX_STATS_EN
  ,
  output logic [15:0]            good_cnt,
  output logic [15:0]            bad_cnt
`endif
);

  logic                   w_bit_valid;
  logic                   w_bit_val;
  logic                   w_bit_err;
  logic [7:0]             w_byte;
  logic [2:0]             w_last_idx;
  logic [8*MAX_BYTES-1:0] w_data_out;

  rx_state_e              r_state;
  logic [4:0]             r_ones;
  logic [2:0]             r_bitcnt;
  logic [6:0]             r_shift;
  logic [2:0]             r_idx;
  logic [7:0]             r_xor;
  logic [8*MAX_BYTES-1:0] r_buf;
  logic                   r_pkt_valid;
  logic                   r_pkt_err;
  logic [1:0]             r_err_code;
  logic [8*MAX_BYTES-1:0] r_pkt_data;
  logic [2:0]             r_pkt_len;

  dcc_bit_slicer #(
    .ONE_MIN  (ONE_MIN),
    .ONE_MAX  (ONE_MAX),
    .ZERO_MIN (ZERO_MIN),
    .ZERO_MAX (ZERO_MAX),
    .CNT_W    (CNT_W)
  ) u_slicer (
    .clk       (clk),
    .reset     (reset),
    .track_in  (track_in),
    .bit_valid (w_bit_valid),
    .bit_val   (w_bit_val),
    .bit_err   (w_bit_err)
  );

  assign w_byte     = {r_shift, w_bit_val};
  assign w_last_idx = r_idx - 3'd1;

  // The last stored byte is the error byte and is not presented.
  always_comb begin
    w_data_out = r_buf;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (3'(i) == w_last_idx) begin
        w_data_out[i*8 +: 8] = 8'h00;
      end else begin
        w_data_out[i*8 +: 8] = r_buf[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PREAMBLE;
      r_ones      <= 5'd0;
      r_bitcnt    <= 3'd0;
      r_shift     <= 7'd0;
      r_idx       <= 3'd0;
      r_xor       <= 8'h00;
      r_buf       <= {(8*MAX_BYTES){1'b0}};
      r_pkt_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= 2'b00;
      r_pkt_data  <= {(8*MAX_BYTES){1'b0}};
      r_pkt_len   <= 3'd0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
      case (r_state)
        PREAMBLE: begin
          if (w_bit_err) begin
            r_ones <= 5'd0;
          end else if (w_bit_valid) begin
            if (w_bit_val) begin
              if (r_ones != 5'd31) r_ones <= r_ones + 5'd1;
            end else if (r_ones >= 5'(PREAMBLE_MIN)) begin
              r_state  <= BYTE;
              r_bitcnt <= 3'd0;
              r_idx    <= 3'd0;
              r_xor    <= 8'h00;
              r_buf    <= {(8*MAX_BYTES){1'b0}};
            end else begin
              r_ones <= 5'd0;
            end
          end
        end
        BYTE: begin
          if (w_bit_err) begin
            r_pkt_err  <= 1'b1;
            r_err_code <= ERR_TIMING;
            r_ones     <= 5'd0;
            r_state    <= PREAMBLE;
          end else if (w_bit_valid) begin
            r_shift  <= {r_shift[5:0], w_bit_val};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              for (int i = 0; i < MAX_BYTES; i++) begin
                if (r_idx == 3'(i)) r_buf[i*8 +: 8] <= w_byte;
              end
              r_xor   <= r_xor ^ w_byte;
              r_idx   <= r_idx + 3'd1;
              r_state <= SEP;
            end
          end
        end
        SEP: begin
          if (w_bit_err) begin
            r_pkt_err  <= 1'b1;
            r_err_code <= ERR_TIMING;
            r_ones     <= 5'd0;
            r_state    <= PREAMBLE;
          end else if (w_bit_valid) begin
            if (!w_bit_val) begin
              if (r_idx >= 3'(MAX_BYTES)) begin
                r_pkt_err  <= 1'b1;
                r_err_code <= ERR_OVERFLOW;
                r_ones     <= 5'd0;
                r_state    <= PREAMBLE;
              end else begin
                r_bitcnt <= 3'd0;
                r_state  <= BYTE;
              end
            end else begin
              // The end bit doubles as the first bit of the next preamble.
              r_ones  <= 5'd1;
              r_state <= PREAMBLE;
              if (r_idx < 3'd3) begin
                r_pkt_err  <= 1'b1;
                r_err_code <= ERR_SHORT;
              end else if (r_xor != 8'h00) begin
                r_pkt_err  <= 1'b1;
                r_err_code <= ERR_CHECKSUM;
              end else begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= w_data_out;
                r_pkt_len   <= w_last_idx;
              end
            end
          end
        end
        default: begin
          r_ones  <= 5'd0;
          r_state <= PREAMBLE;
        end
      endcase
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_err   = r_pkt_err;
  assign err_code  = r_err_code;
  assign pkt_data  = r_pkt_data;
  assign pkt_len   = r_pkt_len;

`ifdef DCC_RX_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_good_cnt <= 16'd0;
      r_bad_cnt  <= 16'd0;
    end else begin
      if (r_pkt_valid) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_pkt_err)   r_bad_cnt  <= r_bad_cnt + 16'd1;
    end
  end

  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_dcc_rx.sv
// Directed bench for dcc_rx: drives DCC waveforms on track_in and checks each
// packet pulse against a queue of expected outcomes.
module tb_dcc_rx;
  import dcc_pkg::*;

  localparam int HALF1 = 55;
  localparam int HALF0 = 95;
  localparam int GAP   = 300;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [2:0]  len;
    logic [47:0] data;
  } exp_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        track_in = 1'b0;
  logic        pkt_valid;
  logic [47:0] pkt_data;
  logic [2:0]  pkt_len;
  logic        pkt_err;
  logic [1:0]  err_code;
`ifdef DCC_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  dcc_rx dut (
    .clk       (clk),
    .reset     (reset),
    .track_in  (track_in),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_len   (pkt_len),
    .pkt_err   (pkt_err),
    .err_code  (err_code)
`ifdef DCC_RX_STATS_EN
    ,
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic toggle_wait(input int cycles);
    track_in = ~track_in;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    toggle_wait(b ? HALF1 : HALF0);
    toggle_wait(b ? HALF1 : HALF0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input int pre, input int nbytes, input logic [63:0] data);
    repeat (pre) send_bit(1'b1);
    for (int i = 0; i < nbytes; i++) begin
      send_bit(1'b0);
      send_byte(data[i*8 +: 8]);
    end
    send_bit(1'b1);
  endtask

  // Closes the end bit, then one '0' bit to clear the preamble count, then idles.
  task automatic flush();
    toggle_wait(HALF0);
    toggle_wait(HALF0);
    toggle_wait(GAP);
  endtask

  task automatic push_ok(input logic [2:0] len, input logic [47:0] data);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.len = len; e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 3'd0; e.data = 48'h0;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(pkt_valid), 64'd0);
    chk({tag, "_err"},   64'(pkt_err),   64'd0);
    chk({tag, "_code"},  64'(err_code),  64'd0);
    chk({tag, "_data"},  64'(pkt_data),  64'd0);
    chk({tag, "_len"},   64'(pkt_len),   64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && (pkt_valid || pkt_err)) begin
      chk("exclusive", 64'(pkt_valid & pkt_err), 64'd0);
      chk("pulse_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pulse_kind", 64'(pkt_err), 64'(mon_e.is_err));
        if (mon_e.is_err) begin
          chk("err_code", 64'(err_code), 64'(mon_e.code));
        end else begin
          chk("pkt_len", 64'(pkt_len), 64'(mon_e.len));
          chk("pkt_data", 64'(pkt_data), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (GAP) @(negedge clk);

    // Idle packet
    push_ok(3'd2, 48'h0000_0000_00FF);
    send_frame(14, 3, 64'h0000_0000_00FF_00FF);
    flush();
    chk("drain_idle", 64'(sb.size()), 64'd0);

    // Bad checksum; previous packet data must hold
    push_err(ERR_CHECKSUM);
    send_frame(14, 3, 64'h0000_0000_003D_3F03);
    flush();
    chk("drain_cksum", 64'(sb.size()), 64'd0);
    chk("hold_data", 64'(pkt_data), 64'h0000_0000_00FF);
    chk("hold_len", 64'(pkt_len), 64'd2);

    // Nine ones are not enough; ten are
    send_frame(9, 3, 64'h0000_0000_003C_3F03);
    flush();
    chk("drain_short_pre", 64'(sb.size()), 64'd0);
    push_ok(3'd2, 48'h0000_0000_3F03);
    send_frame(10, 3, 64'h0000_0000_003C_3F03);
    flush();
    chk("drain_pre10", 64'(sb.size()), 64'd0);

    // Over-long half-bit mid-byte, then recovery
    push_err(ERR_TIMING);
    repeat (14) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    toggle_wait(12000);
    toggle_wait(GAP);
    chk("drain_timing", 64'(sb.size()), 64'd0);
    push_ok(3'd2, 48'h0000_0000_00FF);
    send_frame(14, 3, 64'h0000_0000_00FF_00FF);
    flush();
    chk("drain_recover", 64'(sb.size()), 64'd0);

    // Seven bytes overflow the buffer
    push_err(ERR_OVERFLOW);
    send_frame(14, 7, 64'h00FF_FFFF_FFFF_FFFF);
    flush();
    chk("drain_overflow", 64'(sb.size()), 64'd0);

    // Reset during the second byte
    repeat (14) send_bit(1'b1);
    send_bit(1'b0);
    send_byte(8'h03);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("drain_reset", 64'(sb.size()), 64'd0);

    // Back-to-back: end bit counts toward the next preamble
    push_ok(3'd2, 48'h0000_0000_00FF);
    push_ok(3'd2, 48'h0000_0000_3F03);
    send_frame(14, 3, 64'h0000_0000_00FF_00FF);
    send_frame(9, 3, 64'h0000_0000_003C_3F03);
    flush();
    chk("drain_b2b", 64'(sb.size()), 64'd0);

`ifdef DCC_RX_STATS_EN
    chk("good_cnt", 64'(good_cnt), 64'd2);
    chk("bad_cnt", 64'(bad_cnt), 64'd0);
`endif

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
